// File: rtl/sync_timing_pkg.sv
// Shared types and constants for the line/frame sync timing generator.
package sync_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LINE,
    ST_GAP
  } state_t;

  localparam int PERIOD_W = 13;
  localparam int LINE_W   = 5;
  localparam int FCNT_W   = 16;

  localparam int DEF_LINES      = 24;
  localparam int DEF_MIN_PERIOD = 16;
  localparam int DEF_FRAME_GAP  = 16;

endpackage

// File: rtl/sync_line_timer.sv
// In-line position counter with a clamped, frame-latched line period.
module sync_line_timer
  import sync_timing_pkg::*;
#(
  parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                clear,
  input  logic                en,
  input  logic [PERIOD_W-1:0] line_period,
  output logic                line_end,
  output logic                near_end
);

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= MIN_P;
      pos    <= '0;
    end else if (clear) begin
      pos <= '0;
    end else if (load) begin
      period <= (line_period < MIN_P) ? MIN_P : line_period;
      pos    <= '0;
    end else if (en) begin
      pos <= line_end ? '0 : pos + 1'b1;
    end
  end

  // near_end lets the top register frame_done one cycle ahead of the last position
  assign line_end = (pos == period - PERIOD_W'(1));
  assign near_end = (pos == period - PERIOD_W'(2));

endmodule

// File: rtl/sync_timing_gen.sv
// Line/frame sync generator: IDLE/LINE/GAP sequencer with registered outputs.
// Build with SYNC_TIMING_FRAME_CNT_EN to include the completed-frame counter.
module sync_timing_gen
  import sync_timing_pkg::*;
#(
  parameter int LINES_PER_FRAME = DEF_LINES,
  parameter int FRAME_GAP       = DEF_FRAME_GAP,
  parameter int MIN_PERIOD      = DEF_MIN_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  input  logic                stop,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] line_period,
  output logic                f_sync,
  output logic                sync,
  output logic [LINE_W-1:0]   line_idx,
  output logic                busy,
  output logic                frame_done,
  output logic [FCNT_W-1:0]   frame_cnt
);

  localparam int GAP_W = $clog2(FRAME_GAP + 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(FRAME_GAP - 1);

  state_t            state, state_n;
  logic [LINE_W-1:0] line_idx_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic              stop_req, stop_req_n;
  logic              cont, cont_n;
  logic              sync_n, f_sync_n, frame_done_n, busy_n;
  logic              load, fc_inc;
  logic              line_end, near_end;

  sync_line_timer #(.MIN_PERIOD(MIN_PERIOD)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .clear       (abort),
    .en          (state == ST_LINE),
    .line_period (line_period),
    .line_end    (line_end),
    .near_end    (near_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      line_idx   <= '0;
      gap_cnt    <= '0;
      stop_req   <= 1'b0;
      cont       <= 1'b0;
      sync       <= 1'b0;
      f_sync     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      line_idx   <= line_idx_n;
      gap_cnt    <= gap_n;
      stop_req   <= stop_req_n;
      cont       <= cont_n;
      sync       <= sync_n;
      f_sync     <= f_sync_n;
      frame_done <= frame_done_n;
      busy       <= busy_n;
    end
  end

  // Outputs are computed for the next cycle so they leave the block from flops
  always_comb begin
    state_n      = state;
    line_idx_n   = line_idx;
    gap_n        = gap_cnt;
    stop_req_n   = stop_req;
    cont_n       = cont;
    sync_n       = 1'b0;
    f_sync_n     = 1'b0;
    frame_done_n = 1'b0;
    load         = 1'b0;
    fc_inc       = 1'b0;
    if (abort) begin
      state_n    = ST_IDLE;
      line_idx_n = '0;
      gap_n      = '0;
      stop_req_n = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state_n    = ST_LINE;
            load       = 1'b1;
            line_idx_n = '0;
            cont_n     = continuous & ~stop;
            stop_req_n = 1'b0;
            sync_n     = 1'b1;
            f_sync_n   = 1'b1;
          end
        end
        ST_LINE: begin
          if (stop) stop_req_n = 1'b1;
          if (line_end) begin
            if (line_idx == LAST_LINE) begin
              fc_inc     = 1'b1;
              stop_req_n = 1'b0;
              gap_n      = '0;
              line_idx_n = '0;
              state_n    = (cont && !stop_req) ? ST_GAP : ST_IDLE;
            end else begin
              line_idx_n = line_idx + 1'b1;
              sync_n     = 1'b1;
            end
          end else if (near_end && line_idx == LAST_LINE) begin
            frame_done_n = 1'b1;
          end
        end
        ST_GAP: begin
          if (stop) stop_req_n = 1'b1;
          if (gap_cnt == GAP_LAST) begin
            state_n    = ST_LINE;
            load       = 1'b1;
            line_idx_n = '0;
            gap_n      = '0;
            cont_n     = continuous;
            sync_n     = 1'b1;
            f_sync_n   = 1'b1;
          end else begin
            gap_n = gap_cnt + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
    busy_n = (state_n != ST_IDLE);
  end

`ifdef SYNC_TIMING_FRAME_CNT_EN
  logic [FCNT_W-1:0] fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fcnt <= '0;
    else if (fc_inc) fcnt <= fcnt + 1'b1;
  end

  assign frame_cnt = fcnt;
`else
  logic unused_fc_inc;

  assign unused_fc_inc = fc_inc;
  assign frame_cnt     = '0;
`endif

endmodule
